// File: rtl/sms_input_ctrl.sv
// sms_input_ctrl: debounced joypad/pause controller serving SMS I/O ports $DC/$DD and the pause NMI
module sms_input_ctrl #(
    parameter int TICK_CYCLES = 25000,
    parameter int NMI_CYCLES  = 16
) (
    input  logic       clk_25mhz,
    input  logic       rst_n,
    input  logic [6:0] btn,
    input  logic       io_rd_i,
    input  logic [7:0] io_addr_i,
    output logic [7:0] io_data_o,
    output logic       io_ack_o,
    output logic       nmi_n_o,
    output logic [6:0] pad_state_o,
    output logic [7:0] led_o
);
    localparam int PW = $clog2(TICK_CYCLES);
    localparam int CW = $clog2(NMI_CYCLES + 1);
    typedef enum logic {IDLE, PULSE} state_t;
    state_t state, state_nx;
    logic [6:0] sync0, sync1;
    logic [PW-1:0] presc;
    logic tick;
    logic [6:0][3:0] hist, hist_nx;
    logic [6:0] db_nx;
    logic pause_q, pause_rise;
    logic [CW-1:0] cnt, cnt_nx;
    logic nmi_nx;
    logic rd_hit;
    logic [7:0] port_dc;
    logic addr_unused;
    assign tick = presc == PW'(TICK_CYCLES - 1);
    always_ff @(posedge clk_25mhz or negedge rst_n)
        if (!rst_n) begin
            sync0 <= '0;
            sync1 <= '0;
            presc <= '0;
        end else begin
            sync0 <= {btn[6:1], ~btn[0]};
            sync1 <= sync0;
            presc <= tick ? '0 : presc + 1'b1;
        end
    // a bit only flips on a unanimous 4-sample history, otherwise it holds
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            hist_nx[i] = {hist[i][2:0], sync1[i]};
            db_nx[i] = &hist_nx[i] ? 1'b1 : |hist_nx[i] ? pad_state_o[i] : 1'b0;
        end
    end
    always_ff @(posedge clk_25mhz or negedge rst_n)
        if (!rst_n) begin
            hist <= '0;
            pad_state_o <= '0;
        end else if (tick) begin
            hist <= hist_nx;
            pad_state_o <= db_nx;
        end
    assign rd_hit = io_rd_i && io_addr_i[7:6] == 2'b11;
    assign port_dc = {2'b11, ~pad_state_o[2], ~pad_state_o[1], ~pad_state_o[6:3]};
    assign addr_unused = ^io_addr_i[5:1];
    always_ff @(posedge clk_25mhz or negedge rst_n)
        if (!rst_n) begin
            io_data_o <= 8'hFF;
            io_ack_o <= 1'b0;
        end else begin
            io_data_o <= rd_hit ? (io_addr_i[0] ? 8'hFF : port_dc) : io_data_o;
            io_ack_o <= rd_hit;
        end
    assign pause_rise = pad_state_o[0] && !pause_q;
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        nmi_nx = nmi_n_o;
        if (state == IDLE) begin
            if (pause_rise) begin
                state_nx = PULSE;
                cnt_nx = CW'(NMI_CYCLES - 1);
                nmi_nx = 1'b0;
            end
        end else if (cnt == '0) begin
            state_nx = IDLE;
            nmi_nx = 1'b1;
        end else
            cnt_nx = cnt - 1'b1;
    end
    always_ff @(posedge clk_25mhz or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            nmi_n_o <= 1'b1;
            pause_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            nmi_n_o <= nmi_nx;
            pause_q <= pad_state_o[0];
        end
    assign led_o = {~nmi_n_o, pad_state_o};
endmodule

// File: tb/tb_sms_input_ctrl.sv
// tb_sms_input_ctrl: table-driven and directed checks of the SMS joypad/pause controller
module tb_sms_input_ctrl;
    logic clk_25mhz = 1'b0;
    logic rst_n;
    logic [6:0] btn;
    logic io_rd;
    logic [7:0] io_addr;
    logic [7:0] io_data_o;
    logic io_ack_o;
    logic nmi_n_o;
    logic [6:0] pad_state_o;
    logic [7:0] led_o;
    int nvec = 0;
    int nfail = 0;
    int ec;
    sms_input_ctrl #(.TICK_CYCLES(4), .NMI_CYCLES(16)) dut (
        .clk_25mhz(clk_25mhz),
        .rst_n(rst_n),
        .btn(btn),
        .io_rd_i(io_rd),
        .io_addr_i(io_addr),
        .io_data_o(io_data_o),
        .io_ack_o(io_ack_o),
        .nmi_n_o(nmi_n_o),
        .pad_state_o(pad_state_o),
        .led_o(led_o)
    );
    always #5 clk_25mhz = ~clk_25mhz;
    always @(posedge clk_25mhz or negedge rst_n)
        if (!rst_n) ec <= 0;
        else ec <= ec + 1;
    typedef struct {
        logic [6:0] btn;
        logic rd;
        logic [7:0] addr;
        int hold;
        logic ack;
        logic [7:0] data;
        logic [6:0] pad;
    } vec_t;
    vec_t vt[13];
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    task automatic wait_ec(int n);
        for (int k = 0; k < 1000 && ec < n; k++) @(negedge clk_25mhz);
    endtask
    task automatic watch(int n, output int pulses, output int width, output int led_bad, output int lat_bad);
        logic prev_nmi, prev_pad, rose;
        pulses = 0; width = 0; led_bad = 0; lat_bad = 0;
        prev_nmi = nmi_n_o; prev_pad = pad_state_o[0]; rose = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_25mhz);
            if (!nmi_n_o) width++;
            if (prev_nmi && !nmi_n_o) pulses++;
            if (led_o[7] !== ~nmi_n_o) led_bad++;
            if (rose && nmi_n_o) lat_bad++;
            rose = pad_state_o[0] && !prev_pad;
            prev_pad = pad_state_o[0];
            prev_nmi = nmi_n_o;
        end
    endtask
    initial begin
        int e, bad, k, pulses, width, led_bad, lat_bad, first_pad, first_low;
        #100000;
        $display("FAIL watchdog: simulation did not finish, ec=%0d", ec);
        $fatal(1);
    end
    initial begin
        int e, bad, k, pulses, width, led_bad, lat_bad, first_pad, first_low;
        vt[0]  = '{7'h01, 1'b0, 8'h00, 2,  1'b0, 8'hFF, 7'h00};
        vt[1]  = '{7'h01, 1'b1, 8'hDC, 0,  1'b1, 8'hFF, 7'h00};
        vt[2]  = '{7'h01, 1'b0, 8'h00, 0,  1'b0, 8'hFF, 7'h00};
        vt[3]  = '{7'h0B, 1'b0, 8'h00, 40, 1'b0, 8'hFF, 7'h00};
        vt[4]  = '{7'h0B, 1'b1, 8'hDD, 0,  1'b1, 8'hFF, 7'h0A};
        vt[5]  = '{7'h0B, 1'b1, 8'hDC, 0,  1'b1, 8'hEE, 7'h0A};
        vt[6]  = '{7'h0B, 1'b1, 8'h7F, 0,  1'b0, 8'hEE, 7'h0A};
        vt[7]  = '{7'h0B, 1'b1, 8'h3C, 0,  1'b0, 8'hEE, 7'h0A};
        vt[8]  = '{7'h0B, 1'b1, 8'hC1, 0,  1'b1, 8'hFF, 7'h0A};
        vt[9]  = '{7'h0B, 1'b1, 8'hC0, 0,  1'b1, 8'hEE, 7'h0A};
        vt[10] = '{7'h01, 1'b0, 8'h00, 40, 1'b0, 8'hEE, 7'h0A};
        vt[11] = '{7'h01, 1'b1, 8'hDC, 0,  1'b1, 8'hFF, 7'h00};
        vt[12] = '{7'h01, 1'b0, 8'hDC, 0,  1'b0, 8'hFF, 7'h00};
        rst_n = 1'b0; btn = 7'h01; io_rd = 1'b0; io_addr = 8'h00;
        repeat (3) @(negedge clk_25mhz);
        chk("reset outputs", {io_ack_o, io_data_o, nmi_n_o, pad_state_o, led_o}, {1'b0, 8'hFF, 1'b1, 7'h00, 8'h00});
        rst_n = 1'b1;
        foreach (vt[i]) begin
            btn = vt[i].btn; io_rd = vt[i].rd; io_addr = vt[i].addr;
            @(negedge clk_25mhz);
            chk($sformatf("vec%0d ack/data/pad", i), {io_ack_o, io_data_o, pad_state_o}, {vt[i].ack, vt[i].data, vt[i].pad});
            if (vt[i].hold > 0) begin
                io_rd = 1'b0;
                repeat (vt[i].hold) @(negedge clk_25mhz);
            end
        end
        io_rd = 1'b0;
        bad = 0;
        for (int i = 0; i < 108; i++) begin
            btn[5] = ((i / 6) % 2) == 0;
            @(negedge clk_25mhz);
            if (pad_state_o[5]) bad++;
        end
        chk("bounce filtered", bad, 0);
        btn[5] = 1'b1;
        k = 0;
        while (k < 19 && !pad_state_o[5]) begin
            @(negedge clk_25mhz);
            k++;
        end
        chk("stable press within 19", pad_state_o[5], 1'b1);
        btn[5] = 1'b0;
        repeat (40) @(negedge clk_25mhz);
        chk("fire2 released", pad_state_o, 7'h00);
        e = ((ec + 19) / 4 + 1) * 4;
        wait_ec(e - 15);
        btn[6] = 1'b1;
        wait_ec(e - 2);
        io_rd = 1'b1; io_addr = 8'hDC;
        wait_ec(e - 1);
        chk("b2b read 1", {io_ack_o, io_data_o}, {1'b1, 8'hFF});
        wait_ec(e);
        chk("b2b read 2", {io_ack_o, io_data_o}, {1'b1, 8'hFF});
        wait_ec(e + 1);
        chk("b2b read 3", {io_ack_o, io_data_o}, {1'b1, 8'hF7});
        io_rd = 1'b0;
        wait_ec(e + 2);
        chk("b2b ack drop", io_ack_o, 1'b0);
        btn[6] = 1'b0;
        repeat (40) @(negedge clk_25mhz);
        btn[0] = 1'b0;
        watch(200, pulses, width, led_bad, lat_bad);
        chk("pause held pulses", pulses, 1);
        chk("pause pulse width", width, 16);
        chk("led7 tracks nmi", led_bad, 0);
        chk("nmi latency", lat_bad, 0);
        chk("pause debounced", pad_state_o[0], 1'b1);
        btn[0] = 1'b1;
        watch(40, pulses, width, led_bad, lat_bad);
        chk("release no pulse", pulses, 0);
        chk("pause released", pad_state_o[0], 1'b0);
        btn[0] = 1'b0;
        watch(60, pulses, width, led_bad, lat_bad);
        chk("repress pulse", {pulses[7:0], width[7:0]}, {8'd1, 8'd16});
        btn[0] = 1'b1;
        repeat (40) @(negedge clk_25mhz);
        btn[0] = 1'b0;
        k = 0;
        while (k < 40 && nmi_n_o) begin
            @(negedge clk_25mhz);
            k++;
        end
        chk("pulse before reset", nmi_n_o, 1'b0);
        repeat (4) @(negedge clk_25mhz);
        #2 rst_n = 1'b0;
        #1 chk("async reset mid-pulse", {nmi_n_o, pad_state_o, led_o, io_data_o}, {1'b1, 7'h00, 8'h00, 8'hFF});
        repeat (2) @(negedge clk_25mhz);
        rst_n = 1'b1;
        first_pad = -1; first_low = -1; width = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_25mhz);
            if (first_pad < 0 && pad_state_o[0]) first_pad = ec;
            if (first_low < 0 && !nmi_n_o) first_low = ec;
            if (!nmi_n_o) width++;
        end
        chk("held pause debounce cycle", first_pad, 16);
        chk("held pause nmi cycle", first_low, 17);
        chk("held pause nmi width", width, 16);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
